// File: rtl/bidir_rx_pkg.sv
// Shared types and helpers for the bidir rx serial deserializer.
// BIDIR_RX_LSB_FIRST_EN selects LSB-first packing and low-byte strobes.
package bidir_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        END
    } state_e;

    localparam int TUSER_PARTIAL = 0;
    localparam int TUSER_OVF     = 1;
    localparam int MAX_SW        = 8;

    // Byte strobe for a word holding nbits received bits out of sw bytes.
    function automatic logic [MAX_SW-1:0] strb_from_bits(
        input int nbits,
        input int sw
    );
        int nb;
        logic [MAX_SW-1:0] m;
        nb = (nbits + 7) / 8;
        m  = '0;
        for (int i = 0; i < MAX_SW; i++) begin
`ifdef BIDIR_RX_LSB_FIRST_EN
            m[i] = (i < nb) && (i < sw);
`else
            m[i] = (i < sw) && (i >= sw - nb);
`endif
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_buf2.sv
// Two-entry AXI-stream skid FIFO carrying data, strobe, last and user.
// Accepts a push while full when the head is popped in the same cycle.
module axis_buf2 #(
    parameter int DW = 32,
    parameter int SW = 4,
    parameter int UW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic [SW-1:0] s_strb,
    input  logic          s_last,
    input  logic [UW-1:0] s_user,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [SW-1:0] m_strb,
    output logic          m_last,
    output logic [UW-1:0] m_user,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] data_q [2];
    logic [SW-1:0] strb_q [2];
    logic          last_q [2];
    logic [UW-1:0] user_q [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic          wr;
    logic          rd;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign m_valid = !empty;
    assign rd      = m_valid && m_ready;
    assign wr      = s_valid && (!full || rd);

    assign m_data = data_q[rd_ptr];
    assign m_strb = strb_q[rd_ptr];
    assign m_last = last_q[rd_ptr];
    assign m_user = user_q[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                strb_q[i] <= '0;
                last_q[i] <= 1'b0;
                user_q[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr) begin
                data_q[wr_ptr] <= s_data;
                strb_q[wr_ptr] <= s_strb;
                last_q[wr_ptr] <= s_last;
                user_q[wr_ptr] <= s_user;
                wr_ptr         <= ~wr_ptr;
            end
            if (rd) begin
                rd_ptr <= ~rd_ptr;
            end
            if (wr && !rd) begin
                count <= count + 2'd1;
            end else if (rd && !wr) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/bidir_rx_deser.sv
// Framed serial to AXI-stream deserializer with overflow accounting.
// BIDIR_RX_LSB_FIRST_EN: pack LSB-first, right-aligned partial words.
module bidir_rx_deser
    import bidir_rx_pkg::*;
#(
    parameter int DW   = 32,
    parameter int UW   = 4,
    parameter int SW   = DW / 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            frame_n,
    input  logic            bit_en,
    input  logic            sdi,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [DW-1:0]   m_tdata,
    output logic [SW-1:0]   m_tstrb,
    output logic            m_tlast,
    output logic [UW-1:0]   m_tuser,
    output logic            busy,
    output logic [CNTW-1:0] ovf_cnt,
    input  logic            ovf_clr
);

    localparam int CW = $clog2(DW + 1);

    state_e        state;
    state_e        state_d;
    logic [DW-1:0] shreg;
    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] pend;
    logic          pend_v;
    logic          ovf_flag;

    logic          frm_on;
    logic          take;
    logic          word_done;
    logic [DW-1:0] shifted;
    logic [CW-1:0] shamt;
    logic [DW-1:0] part_data;
    logic [SW-1:0] part_strb;
    logic          push;
    logic [DW-1:0] push_data;
    logic [SW-1:0] push_strb;
    logic          push_last;
    logic          push_part;
    logic [UW-1:0] push_user;
    logic          pend_ld;
    logic          pend_clr;
    logic          cnt_clr;
    logic          full;
    logic          empty;
    logic          drop;

    assign frm_on    = enable && !frame_n;
    assign word_done = (bit_cnt == CW'(DW - 1));
    assign shamt     = CW'(DW) - bit_cnt;
    assign part_strb = SW'(strb_from_bits(32'(bit_cnt), SW));

`ifdef BIDIR_RX_LSB_FIRST_EN
    assign shifted   = {sdi, shreg[DW-1:1]};
    assign part_data = shreg >> shamt;
`else
    assign shifted   = {shreg[DW-2:0], sdi};
    assign part_data = shreg << shamt;
`endif

    // Frame state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, bit acceptance and word commit decisions.
    always_comb begin
        state_d   = state;
        take      = 1'b0;
        push      = 1'b0;
        push_data = pend;
        push_strb = '1;
        push_last = 1'b0;
        push_part = 1'b0;
        pend_ld   = 1'b0;
        pend_clr  = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (frm_on) begin
                    state_d = RX;
                    take    = bit_en;
                end
            end
            RX: begin
                if (frm_on) begin
                    take = bit_en;
                end else begin
                    state_d = END;
                end
            end
            END: begin
                if (pend_v) begin
                    push      = 1'b1;
                    pend_clr  = 1'b1;
                    push_last = (bit_cnt == '0);
                    if (bit_cnt == '0) begin
                        state_d = IDLE;
                    end
                end else if (bit_cnt != '0) begin
                    push      = 1'b1;
                    push_data = part_data;
                    push_strb = part_strb;
                    push_last = 1'b1;
                    push_part = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take && word_done) begin
            pend_ld = 1'b1;
            push    = pend_v;
        end
    end

    // Sideband bits travelling with each pushed word.
    always_comb begin
        push_user                = '0;
        push_user[TUSER_PARTIAL] = push_part;
        push_user[TUSER_OVF]     = push_last && ovf_flag;
    end

    assign drop = push && full && !(m_tvalid && m_tready);

    // Shift register, bit counter and single-word pending stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg   <= '0;
            bit_cnt <= '0;
            pend    <= '0;
            pend_v  <= 1'b0;
        end else begin
            if (take) begin
                shreg <= shifted;
            end
            if (take && word_done) begin
                bit_cnt <= '0;
            end else if (take) begin
                bit_cnt <= bit_cnt + CW'(1);
            end else if (cnt_clr) begin
                bit_cnt <= '0;
            end
            if (pend_ld) begin
                pend   <= shifted;
                pend_v <= 1'b1;
            end else if (pend_clr) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Overflow flag persists until a tlast word makes it into the buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_flag <= 1'b0;
        end else if (drop) begin
            ovf_flag <= 1'b1;
        end else if (push && push_last) begin
            ovf_flag <= 1'b0;
        end
    end

    // Saturating dropped-word counter; clear has priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end else if (drop && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNTW'(1);
        end
    end

    axis_buf2 #(
        .DW(DW),
        .SW(SW),
        .UW(UW)
    ) u_buf (
        .clk    (clk),
        .rstn   (rstn),
        .s_valid(push),
        .s_data (push_data),
        .s_strb (push_strb),
        .s_last (push_last),
        .s_user (push_user),
        .m_valid(m_tvalid),
        .m_ready(m_tready),
        .m_data (m_tdata),
        .m_strb (m_tstrb),
        .m_last (m_tlast),
        .m_user (m_tuser),
        .full   (full),
        .empty  (empty)
    );

    assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_bidir_rx_deser.sv
// Bench for bidir_rx_deser: directed scenarios plus random frames.
// Expected beats come from a bit-list frame model in the bench.
module tb_bidir_rx_deser;

    localparam int DW   = 32;
    localparam int UW   = 4;
    localparam int SW   = 4;
    localparam int CNTW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            enable;
    logic            frame_n;
    logic            bit_en;
    logic            sdi;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [SW-1:0]   m_tstrb;
    logic            m_tlast;
    logic [UW-1:0]   m_tuser;
    logic            busy;
    logic [CNTW-1:0] ovf_cnt;
    logic            ovf_clr;

    int    checks   = 0;
    int    failures = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];
    bit    bitq[$];
    bit    sticky    = 1'b0;
    bit    rnd_ready = 1'b0;
    bit    ready_fix = 1'b1;

    always #5 clk = ~clk;

    bidir_rx_deser #(
        .DW(DW),
        .UW(UW),
        .CNTW(CNTW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .frame_n (frame_n),
        .bit_en  (bit_en),
        .sdi     (sdi),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata (m_tdata),
        .m_tstrb (m_tstrb),
        .m_tlast (m_tlast),
        .m_tuser (m_tuser),
        .busy    (busy),
        .ovf_cnt (ovf_cnt),
        .ovf_clr (ovf_clr)
    );

    always @(negedge clk) begin
        if (rstn && m_tvalid && m_tready) begin
            obs_q.push_back({m_tdata, m_tstrb, m_tlast, m_tuser});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        m_tready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
        @(posedge clk);
        #1;
        if (ovf_clr) chk("clr_wins", 64'(ovf_cnt), 64'd0);
    endtask

    function automatic int bpos(input int j);
`ifdef BIDIR_RX_LSB_FIRST_EN
        return j;
`else
        return DW - 1 - j;
`endif
    endfunction

    function automatic int spos(input int k);
`ifdef BIDIR_RX_LSB_FIRST_EN
        return k;
`else
        return SW - 1 - k;
`endif
    endfunction

    task automatic fill_rand(input int n);
        bitq.delete();
        repeat (n) bitq.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int j = 31; j >= 0; j--) bitq.push_back(w[j]);
    endtask

    // Split the frame's bit list into beats the consumer should see.
    task automatic build_exp();
        int    n;
        int    nf;
        int    rem;
        beat_t b;
        n   = bitq.size();
        nf  = n / DW;
        rem = n % DW;
        for (int k = 0; k < nf; k++) begin
            b   = '0;
            for (int j = 0; j < DW; j++) b.d[bpos(j)] = bitq[k*DW+j];
            b.s = '1;
            b.l = (rem == 0) && (k == nf - 1);
            if (b.l) begin
                b.u[1] = sticky;
                sticky = 1'b0;
            end
            exp_q.push_back(b);
        end
        if (rem != 0) begin
            b = '0;
            for (int j = 0; j < rem; j++) b.d[bpos(j)] = bitq[nf*DW+j];
            for (int j = 0; j < rem; j += 8) b.s[spos(j/8)] = 1'b1;
            b.l    = 1'b1;
            b.u[0] = 1'b1;
            b.u[1] = sticky;
            sticky = 1'b0;
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input int gap, input bit by_enable);
        for (int i = 0; i < bitq.size(); i++) begin
            frame_n = 1'b0;
            enable  = 1'b1;
            bit_en  = 1'b1;
            sdi     = bitq[i];
            tick();
            if (gap > 0 && $urandom_range(0, gap) == 0) begin
                bit_en = 1'b0;
                sdi    = 1'($urandom_range(0, 1));
                tick();
            end
        end
        bit_en = 1'b0;
        if (by_enable && bitq.size() > 0) begin
            enable = 1'b0;
            tick();
        end
        frame_n = 1'b1;
        enable  = 1'b1;
        repeat (3) tick();
    endtask

    task automatic drain_cmp(input string tag);
        beat_t e;
        beat_t o;
        for (int i = 0; i < 400 && obs_q.size() < exp_q.size(); i++) tick();
        repeat (4) tick();
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_data"}, 64'(o.d), 64'(e.d));
            chk({tag, "_side"}, 64'({o.s, o.l, o.u}), 64'({e.s, e.l, e.u}));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rstn     = 1'b0;
        enable   = 1'b0;
        frame_n  = 1'b1;
        bit_en   = 1'b0;
        sdi      = 1'b0;
        ovf_clr  = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 64'(m_tvalid), 64'd0);
        chk("rst_data", 64'(m_tdata), 64'd0);
        chk("rst_side", 64'({m_tstrb, m_tlast, m_tuser}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(ovf_cnt), 64'd0);
        rstn = 1'b1;
        tick();

        bitq.delete();
        add_word(32'hDEADBEEF);
        add_word(32'h01234567);
        build_exp();
        send(0, 1'b0);
        drain_cmp("two_words");

        bitq.delete();
        add_word(32'hCAFEBABE);
        for (int j = 7; j >= 0; j--) bitq.push_back(j[0] ^ j[1] ^ 1'b1);
        bitq[32] = 1'b1; bitq[33] = 1'b0; bitq[34] = 1'b1; bitq[35] = 1'b0;
        bitq[36] = 1'b0; bitq[37] = 1'b1; bitq[38] = 1'b0; bitq[39] = 1'b1;
        build_exp();
        send(0, 1'b0);
        drain_cmp("partial");

        ready_fix = 1'b0;
        fill_rand(128);
        build_exp();
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        sticky = 1'b1;
        send(2, 1'b0);
        chk("drop_ovf_cnt", 64'(ovf_cnt), 64'd2);
        chk("drop_valid_held", 64'(m_tvalid), 64'd1);
        chk("drop_no_xfer", 64'(obs_q.size()), 64'd0);
        ready_fix = 1'b1;
        drain_cmp("drop_drain");

        fill_rand(40);
        build_exp();
        send(1, 1'b0);
        drain_cmp("after_ovf");

        frame_n = 1'b0;
        enable  = 1'b1;
        tick();
        frame_n = 1'b1;
        chk("pulse_busy", 64'(busy), 64'd1);
        repeat (3) tick();
        chk("pulse_idle", 64'(busy), 64'd0);
        chk("pulse_no_out", 64'(obs_q.size()), 64'd0);

        for (int i = 0; i < 13; i++) begin
            frame_n = 1'b0;
            bit_en  = 1'b1;
            sdi     = 1'($urandom_range(0, 1));
            tick();
        end
        chk("midrst_busy_pre", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ovf", 64'(ovf_cnt), 64'd0);
        chk("midrst_out", 64'({m_tvalid, m_tdata, m_tstrb, m_tlast, m_tuser}), 64'd0);
        bit_en  = 1'b0;
        frame_n = 1'b1;
        sticky  = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        fill_rand(32);
        build_exp();
        send(0, 1'b0);
        drain_cmp("post_rst");

        ready_fix = 1'b0;
        fill_rand(20 * DW);
        build_exp();
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        sticky = 1'b1;
        send(0, 1'b0);
        chk("sat_ovf", 64'(ovf_cnt), 64'hF);
        ovf_clr = 1'b1;
        fill_rand(96);
        send(0, 1'b0);
        ovf_clr = 1'b0;
        tick();
        chk("clr_ovf", 64'(ovf_cnt), 64'd0);
        ready_fix = 1'b1;
        drain_cmp("sat_drain");

        fill_rand(64);
        build_exp();
        send(0, 1'b0);
        drain_cmp("sat_next");

        rnd_ready = 1'b1;
        for (int f = 0; f < 12; f++) begin
            fill_rand($urandom_range(0, 100));
            build_exp();
            send(3, 1'($urandom_range(0, 1)));
            drain_cmp("rand");
        end
        chk("final_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bidir_rx_deser.md
Name: bidir_rx_deser

Overview:
- Serial-to-AXI-stream deserializer sitting directly upstream of the rx FIFO wrapper; drives the bidir rx stream consumed by it.
- Samples a framed serial line (frame_n active-low, bit_en qualifies each bit) and packs bits MSB-first into DW-bit words.
- Marks the last word of each frame with tlast, flags partial words, and buffers 2 words against backpressure.
- Counts and flags words dropped on overflow.

Parameters:
- DW, 32, stream data width; must be a multiple of 8, 8..64.
- UW, 4, tuser width; must be at least 2.
- SW, DW/8, tstrb width (derived; not overridden).
- CNTW, 16, overflow counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  block enable; when low, bits are ignored and the frame is aborted.
- frame_n  in  1  frame strobe, low = frame active; synchronous to clk.
- bit_en  in  1  sdi valid this cycle.
- sdi  in  1  serial data bit.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tdata  out  DW  stream data.
- m_tstrb  out  SW  byte strobes.
- m_tlast  out  1  last word of frame.
- m_tuser  out  UW  [0] partial word, [1] frame had overflow, others 0.
- busy  out  1  state != IDLE or buffer non-empty.
- ovf_cnt  out  CNTW  dropped-word count, saturating.
- ovf_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0. State IDLE, shift register, bit count, pending register, buffer and ovf_cnt cleared.
- States:
  - IDLE: enter RX when enable=1 and frame_n=0. Bit_en in the entry cycle is accepted.
  - RX: on bit_en, shift sdi in and bit_cnt++. When bit_cnt reaches DW, the word moves to pending with all strobes set.
    - If pending is already occupied, the old pending word is pushed first (tlast=0), in the same cycle.
    - When frame_n=1 or enable=0, go to END.
  - END (1 cycle): commit the frame, then return to IDLE.
    - Partial word present: push pending (tlast=0) if any, then push the partial word (tlast=1) in the following cycle, staying in END for that extra cycle.
    - Partial word: received bits left-aligned, LSBs zero-padded. tstrb bit set for each byte containing at least one received bit. tuser[0]=1.
    - No partial bits: push pending with tlast=1.
    - Frame with 0 bits: nothing pushed.
- Push into the 2-entry buffer:
  - Buffer full: the word is dropped and ovf_cnt increments, saturating at all-ones.
  - The frame's ovf flag is set; the next pushed tlast word carries tuser[1]=1, and the flag clears at frame end.
  - A dropped tlast word means the frame has no tlast on the output.
- Output handshake:
  - Transfer occurs when m_tvalid & m_tready.
  - Data and flags are stable while valid is high and ready is low.
  - Buffer supports push and pop in the same cycle when full.
  - Output latency from the word-completing bit to m_tvalid is 1 cycle from when the word leaves pending.
- ovf_clr and an increment in the same cycle: clear wins.
- enable deasserted mid-frame behaves as frame end; the partial word is still emitted.
- frame_n glitch high for 1 cycle: END completes, and a new frame starts only from IDLE.

Optional Feature:
- Macro BIDIR_RX_LSB_FIRST_EN.
- Defined: bits pack LSB-first; partial words are right-aligned with zero-padded MSBs; tstrb is counted from byte 0 upward.
- Undefined: MSB-first as above.

Decomposition:
- Package bidir_rx_pkg holds:
  - typedef state_e {IDLE, RX, END};
  - tuser bit index constants TUSER_PARTIAL=0, TUSER_OVF=1;
  - function strb_from_bits(bit_cnt) returning the SW-bit strobe.
- Sub-module axis_buf2: 2-entry AXI-stream FIFO carrying data/strb/last/user, with full/empty flags.

Test Plan:
- Frame of 64 bits alternating 0xDEADBEEF, 0x01234567, m_tready=1 -> two words, 0xDEADBEEF tlast=0 then 0x01234567 tlast=1, tstrb=0xF, tuser=0.
- Frame of 40 bits 0xCAFEBABE then 0xA5 -> 0xCAFEBABE tlast=0, then 0xA5000000 tstrb=0x8 tuser=0x1 tlast=1.
- m_tready=0, frame of 4 full words -> first 2 buffered, 2 dropped. ovf_cnt=2. With ready raised, 2 words out, no tlast. Next frame's tlast word has tuser[1]=1.
- frame_n pulse low with no bit_en -> no output, busy returns 0 after END.
- Reset asserted mid-frame after 13 bits -> all outputs 0 immediately. A following 32-bit frame yields exactly one clean word.
- ovf_cnt at 0xFFFF plus another drop -> stays 0xFFFF. ovf_clr together with a drop -> 0.
